// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Parametrised UART transmit framer. Accepts one word over a valid/ready
//   handshake and serialises it as: start bit (0), DATA_W data bits LSB-first,
//   an optional parity bit, then one or two stop bits (1). Bit timing is
//   derived from the external baud_tick strobe, TICKS_PER_BIT ticks per bit.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   baud_tick    one-cycle bit-timing strobe
//   in_data      word to transmit
//   in_valid     in_data valid
//   in_ready     framer can accept a word (high only when idle)
//   parity_mode  00/11 none, 01 even, 10 odd (latched at accept)
//   stop2        1 = two stop bits, 0 = one (latched at accept)
//   txd          serial line, idles high
//   busy         frame in progress
//   frame_done   one-cycle pulse on the edge the frame completes
module uart_tx_framer #(
  parameter int DATA_W        = 8,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              paren_q, paren_d;
  logic              stop2_q, stop2_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              period_end;

  // Even mode sends the XOR of the data; odd mode (10) sends its complement.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d,
                                      input logic [1:0] mode);
    return (^d) ^ (mode == 2'b10);
  endfunction

  assign period_end = baud_tick && (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    paren_d = paren_q;
    stop2_d = stop2_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE && baud_tick) begin
      tick_d = period_end ? '0 : tick_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          shreg_d = in_data;
          par_d   = parity_bit(in_data, parity_mode);
          paren_d = ^parity_mode;           // 01 or 10 enable parity
          stop2_d = stop2;
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_START;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      S_START: begin
        if (period_end) begin
          state_d = S_DATA;
          txd_d   = shreg_q[0];
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (period_end) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;                     // reused below as stop-bit index
            if (paren_q) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (period_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (period_end) begin
          if (stop2_q && bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            done_d  = 1'b1;
            bit_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      paren_q <= 1'b0;
      stop2_q <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      paren_q <= paren_d;
      stop2_q <= stop2_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign in_ready   = ready_q;
  assign frame_done = done_q;

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Parametrised UART transmit framer; successor to the fixed 12-bit TX shift register.
- Accepts a data word over a valid/ready handshake and serialises one frame: start bit, DATA_W data bits LSB-first, optional parity, then 1 or 2 stop bits.
- Bit timing comes from an external baud_tick strobe divided internally by TICKS_PER_BIT.
- Sits between the TX holding logic and the txd pin.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- TICKS_PER_BIT, 16, baud_tick pulses per bit period; legal range 1..256.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- baud_tick  in  1  one-cycle bit-timing strobe.
- in_data  in  DATA_W  word to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  framer can accept a word.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- stop2  in  1  1 = two stop bits, 0 = one.
- txd  out  1  serial line; idles high.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset:
  - Applied on a clk edge with reset=1.
  - Outputs after reset: txd=1, busy=0, in_ready=1, frame_done=0.
  - FSM goes to IDLE; counters and shift register clear to 0.
  - Reset overrides everything, including mid-frame: txd returns to 1 at the reset edge and the partial frame is abandoned.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - txd=1, busy=0, in_ready=1.
  - Accept occurs on an edge with in_valid & in_ready.
  - At accept, latch in_data, parity_mode and stop2 for the whole frame.
  - Parity latched = XOR of in_data (even mode) or its complement (odd mode).
  - Clear tick_cnt and bit_cnt; go to START.
  - From the accept edge onward: txd=0, busy=1, in_ready=0.
- Config and input changes after accept have no effect on the current frame. in_valid while busy is ignored and the word is not consumed.
- Bit period:
  - Each non-IDLE state holds its txd value until TICKS_PER_BIT baud_tick pulses have been counted.
  - tick_cnt increments only on baud_tick.
  - The period ends on the edge where baud_tick=1 and tick_cnt==TICKS_PER_BIT-1; tick_cnt then returns to 0.
  - Cycles without baud_tick do not advance anything.
- START: txd=0. At period end go to DATA with txd=shreg[0].
- DATA:
  - Shift right one bit per period.
  - After DATA_W periods (bit_cnt==DATA_W-1 at period end), go to PARITY if parity enabled, else STOP.
- PARITY: txd=latched parity for one period, then go to STOP.
- STOP:
  - txd=1 for one period (stop2=0) or two periods (stop2=1).
  - At the final period end: go to IDLE, assert frame_done for exactly one cycle, busy=0, in_ready=1 (same edge).
- Back-to-back frames:
  - A word presented with in_valid held is accepted on the first edge that in_ready=1 is sampled, i.e. the edge after frame_done rises.
  - Minimum idle gap is therefore one clk cycle.
- Widths:
  - tick_cnt is $clog2(TICKS_PER_BIT) bits, minimum 1.
  - bit_cnt is $clog2(DATA_W) bits, minimum 1.
  - With TICKS_PER_BIT=1, every baud_tick ends a period.
- Frame length in bit periods = 1 + DATA_W + (parity?1:0) + (stop2?2:1).

Test Plan:
- Plain frame, 8N1:
  - Setup: DATA_W=8, TPB=1, baud_tick=1 continuously; send 0xA5, parity 00, stop2=0.
  - Required: txd per period 0,1,0,1,0,0,1,0,1,1; frame_done one cycle after the 10th period; busy high for exactly 10 cycles.
- Parity:
  - Same setup, 0xA5 with parity 01 → parity bit 0.
  - Same setup, 0xA5 with parity 10 → parity bit 1.
  - 0x07 with parity 01 → parity bit 1.
  - Each frame is 11 periods.
- Two stop bits and tick gating:
  - Setup: TPB=16, baud_tick every 4th cycle, stop2=1, DATA_W=7, send 0x55.
  - Required: every bit lasts 64 cycles; frame = 10 periods (640 cycles); txd=1 throughout both stop periods.
- Handshake:
  - Hold in_valid=1 with 0x3C then 0xC3 across two frames.
  - Required: each word is accepted once; in_ready=0 while busy; the second start bit begins one cycle after frame_done; a word changed while busy is not transmitted.
- Mid-frame reset:
  - Assert reset during DATA bit 3.
  - Required: txd=1, busy=0, in_ready=1 at the reset edge; a following frame 0x81 transmits correctly.
- Config latch:
  - Toggle parity_mode and stop2 during a frame.
  - Required: the frame uses the values latched at accept.
